// File: rtl/fft_sink_feeder.sv
// ============================================================================
// fft_sink_feeder : FWFT sample FIFO feeding an FFT core sink port in frames.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sink_feeder #(
  parameter int LOG2_N     = 15,
  parameter int DW         = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int THRESH     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_real,
  input  logic [DW-1:0]     in_imag,
  input  logic              master_sink_ena,
  output logic              master_sink_dav,
  output logic              master_sink_sop,
  output logic [DW-1:0]     data_real_in,
  output logic [DW-1:0]     data_imag_in,
  output logic [15:0]       frame_count,
  output logic              underflow
);

  localparam int                  c_depth     = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] c_depth_cnt = (LOG2_DEPTH+1)'(c_depth);
  localparam logic [LOG2_DEPTH:0] c_thresh    = (LOG2_DEPTH+1)'(THRESH);
  localparam logic [0:0]          c_st_idle   = 1'b0;
  localparam logic [0:0]          c_st_stream = 1'b1;

  logic [2*DW-1:0]       mem_q [c_depth];
  logic [2*DW-1:0]       mem_d [c_depth];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic [LOG2_N-1:0]     sample_idx_q, sample_idx_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  underflow_q, underflow_d;
  logic [0:0]            state_q, state_d;

  logic w_push, w_xfer, w_pop, w_empty, w_last;

  // FIFO and frame datapath
  always_comb begin
    w_empty  = (count_q == '0);
    in_ready = (count_q < c_depth_cnt);
    w_push   = in_valid & in_ready;
    w_xfer   = master_sink_dav & master_sink_ena;
    w_pop    = w_xfer & ~w_empty;
    w_last   = (sample_idx_q == '1);

    mem_d = mem_q;
    if (w_push) mem_d[wr_ptr_q] = {in_real, in_imag};
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    sample_idx_d  = w_xfer ? sample_idx_q + 1'b1 : sample_idx_q;
    frame_count_d = (w_xfer && w_last) ? frame_count_q + 16'd1 : frame_count_q;
    // An empty-FIFO transfer can only happen in STREAM; zeros go out instead.
    underflow_d   = underflow_q | (w_xfer & w_empty);

    data_real_in = w_empty ? '0 : mem_q[rd_ptr_q][2*DW-1:DW];
    data_imag_in = w_empty ? '0 : mem_q[rd_ptr_q][DW-1:0];
    frame_count  = frame_count_q;
    underflow    = underflow_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= c_st_idle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sample_idx_q  <= '0;
      frame_count_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sample_idx_q  <= sample_idx_d;
      frame_count_q <= frame_count_d;
      underflow_q   <= underflow_d;
    end
  end

  // Next state: a frame is only re-armed at its end when enough data is queued
  always_comb begin
    state_d = state_q;
    if (w_xfer) begin
      if (w_last) state_d = (count_d >= c_thresh) ? c_st_stream : c_st_idle;
      else        state_d = c_st_stream;
    end
  end

  always_comb begin
    master_sink_dav = (state_q == c_st_stream) | (count_q >= c_thresh);
    master_sink_sop = master_sink_dav & (sample_idx_q == '0);
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_sink_feeder.sv
// ============================================================================
// tb_fft_sink_feeder : directed self-checking bench for fft_sink_feeder.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_sink_feeder;

  logic        clk = 1'b0;
  logic        reset, in_valid, ena;
  logic [15:0] in_real, in_imag;

  logic        rdy_a, dav_a, sop_a, uf_a;
  logic [15:0] dr_a, di_a, fc_a;
  logic        rdy_b, dav_b, sop_b, uf_b;
  logic [15:0] dr_b, di_b, fc_b;

  int checks = 0;
  int errors = 0;

  fft_sink_feeder #(.LOG2_N(3), .DW(16), .LOG2_DEPTH(4), .THRESH(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_real(in_real), .in_imag(in_imag), .master_sink_ena(ena),
    .master_sink_dav(dav_a), .master_sink_sop(sop_a),
    .data_real_in(dr_a), .data_imag_in(di_a),
    .frame_count(fc_a), .underflow(uf_a)
  );

  // Lower threshold lets a frame start with fewer samples than its length.
  fft_sink_feeder #(.LOG2_N(3), .DW(16), .LOG2_DEPTH(4), .THRESH(5)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_real(in_real), .in_imag(in_imag), .master_sink_ena(ena),
    .master_sink_dav(dav_b), .master_sink_sop(sop_b),
    .data_real_in(dr_b), .data_imag_in(di_b),
    .frame_count(fc_b), .underflow(uf_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] sre(input int k);
    return 16'(4096 + k);
  endfunction

  function automatic logic [15:0] sim(input int k);
    return 16'(61440 - k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; in_valid = 1'b0; ena = 1'b0; in_real = '0; in_imag = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic push_n(input int base, input int n, input logic e);
    ena = e;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_real = sre(base + i); in_imag = sim(base + i);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (dav_a !== 1'b0) begin errors++; $display("FAIL reset_dav: got %b want 0", dav_a); end
    checks++; if (sop_a !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b want 0", sop_a); end
    checks++; if (dr_a !== 16'h0) begin errors++; $display("FAIL reset_dr: got %h want 0", dr_a); end
    checks++; if (di_a !== 16'h0) begin errors++; $display("FAIL reset_di: got %h want 0", di_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
    checks++; if (fc_a !== 16'h0) begin errors++; $display("FAIL reset_fc: got %h want 0", fc_a); end
    checks++; if (uf_a !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b want 0", uf_a); end
  endtask

  task automatic test_threshold;
    do_reset;
    ena = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_n(i, 1, 1'b1);
      checks++; if (dav_a !== 1'b0) begin errors++; $display("FAIL thr_dav_early[%0d]: got %b want 0", i, dav_a); end
    end
    push_n(7, 1, 1'b1);
    checks++; if (dav_a !== 1'b1) begin errors++; $display("FAIL thr_dav: got %b want 1", dav_a); end
    checks++; if (sop_a !== 1'b1) begin errors++; $display("FAIL thr_sop: got %b want 1", sop_a); end
    checks++; if (dr_a !== sre(0)) begin errors++; $display("FAIL thr_dr: got %h want %h", dr_a, sre(0)); end
    checks++; if (di_a !== sim(0)) begin errors++; $display("FAIL thr_di: got %h want %h", di_a, sim(0)); end
  endtask

  task automatic test_stream;
    int pushed = 0;
    int xfers = 0;
    logic rdy;
    do_reset;
    ena = 1'b1;
    for (int cyc = 0; cyc < 40 && xfers < 16; cyc++) begin
      in_valid = (pushed < 16); in_real = sre(pushed); in_imag = sim(pushed);
      if (dav_a === 1'b1) begin
        checks++; if (dr_a !== sre(xfers)) begin errors++; $display("FAIL stream_dr[%0d]: got %h want %h", xfers, dr_a, sre(xfers)); end
        checks++; if (di_a !== sim(xfers)) begin errors++; $display("FAIL stream_di[%0d]: got %h want %h", xfers, di_a, sim(xfers)); end
        checks++; if (sop_a !== (xfers % 8 == 0)) begin errors++; $display("FAIL stream_sop[%0d]: got %b want %b", xfers, sop_a, (xfers % 8 == 0)); end
        xfers++;
      end
      rdy = rdy_a;
      tick;
      if (in_valid && rdy) pushed++;
    end
    in_valid = 1'b0; ena = 1'b0;
    checks++; if (xfers != 16) begin errors++; $display("FAIL stream_xfers: got %0d want 16", xfers); end
    checks++; if (fc_a !== 16'd2) begin errors++; $display("FAIL stream_fc: got %0d want 2", fc_a); end
    checks++; if (uf_a !== 1'b0) begin errors++; $display("FAIL stream_uf: got %b want 0", uf_a); end
    checks++; if (dav_a !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b want 0", dav_a); end
  endtask

  task automatic test_underflow;
    logic [15:0] er, ei;
    do_reset;
    push_n(0, 5, 1'b0);
    ena = 1'b1;
    for (int t = 0; t < 8; t++) begin
      er = (t < 5) ? sre(t) : 16'h0;
      ei = (t < 5) ? sim(t) : 16'h0;
      checks++; if (dav_b !== 1'b1) begin errors++; $display("FAIL uf_dav[%0d]: got %b want 1", t, dav_b); end
      checks++; if (dr_b !== er) begin errors++; $display("FAIL uf_dr[%0d]: got %h want %h", t, dr_b, er); end
      checks++; if (di_b !== ei) begin errors++; $display("FAIL uf_di[%0d]: got %h want %h", t, di_b, ei); end
      checks++; if (uf_b !== (t > 5)) begin errors++; $display("FAIL uf_flag[%0d]: got %b want %b", t, uf_b, (t > 5)); end
      tick;
    end
    ena = 1'b0;
    checks++; if (uf_b !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", uf_b); end
    checks++; if (fc_b !== 16'd1) begin errors++; $display("FAIL uf_fc: got %0d want 1", fc_b); end
    checks++; if (dav_b !== 1'b0) begin errors++; $display("FAIL uf_idle: got %b want 0", dav_b); end
  endtask

  task automatic test_full;
    do_reset;
    push_n(0, 1, 1'b0);
    checks++; if (dr_a !== sre(0)) begin errors++; $display("FAIL lat_dr: got %h want %h", dr_a, sre(0)); end
    push_n(1, 15, 1'b0);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", rdy_a); end
    push_n(100, 1, 1'b0);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL full_ready2: got %b want 0", rdy_a); end
    checks++; if (dr_a !== sre(0)) begin errors++; $display("FAIL full_head: got %h want %h", dr_a, sre(0)); end
    in_valid = 1'b1; in_real = sre(101); in_imag = sim(101); ena = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL full_ready3: got %b want 1", rdy_a); end
    for (int k = 1; k < 16; k++) begin
      checks++; if (dr_a !== sre(k)) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", k, dr_a, sre(k)); end
      tick;
    end
    ena = 1'b0;
    checks++; if (dr_a !== 16'h0) begin errors++; $display("FAIL full_empty: got %h want 0", dr_a); end
    checks++; if (dav_a !== 1'b0) begin errors++; $display("FAIL full_idle: got %b want 0", dav_a); end
    checks++; if (fc_a !== 16'd2) begin errors++; $display("FAIL full_fc: got %0d want 2", fc_a); end
    checks++; if (uf_a !== 1'b0) begin errors++; $display("FAIL full_uf: got %b want 0", uf_a); end
  endtask

  task automatic test_ena_toggle;
    logic pat [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int adv = 0;
    do_reset;
    push_n(0, 16, 1'b0);
    for (int p = 0; p < 12; p++) begin
      ena = pat[p];
      checks++; if (dr_a !== sre(adv)) begin errors++; $display("FAIL ena_dr[%0d]: got %h want %h", p, dr_a, sre(adv)); end
      checks++; if (sop_a !== (adv % 8 == 0)) begin errors++; $display("FAIL ena_sop[%0d]: got %b want %b", p, sop_a, (adv % 8 == 0)); end
      tick;
      if (pat[p]) adv++;
    end
    ena = 1'b0;
    checks++; if (dr_a !== sre(adv)) begin errors++; $display("FAIL ena_final: got %h want %h", dr_a, sre(adv)); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    push_n(0, 8, 1'b0);
    ena = 1'b1;
    tick; tick; tick;
    ena = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (dav_a !== 1'b0) begin errors++; $display("FAIL mid_dav: got %b want 0", dav_a); end
    checks++; if (sop_a !== 1'b0) begin errors++; $display("FAIL mid_sop: got %b want 0", sop_a); end
    checks++; if (dr_a !== 16'h0) begin errors++; $display("FAIL mid_dr: got %h want 0", dr_a); end
    checks++; if (di_a !== 16'h0) begin errors++; $display("FAIL mid_di: got %h want 0", di_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", rdy_a); end
    checks++; if (fc_a !== 16'h0) begin errors++; $display("FAIL mid_fc: got %0d want 0", fc_a); end
    push_n(512, 8, 1'b0);
    checks++; if (dav_a !== 1'b1) begin errors++; $display("FAIL mid_restart_dav: got %b want 1", dav_a); end
    checks++; if (sop_a !== 1'b1) begin errors++; $display("FAIL mid_restart_sop: got %b want 1", sop_a); end
    checks++; if (dr_a !== sre(512)) begin errors++; $display("FAIL mid_restart_dr: got %h want %h", dr_a, sre(512)); end
    checks++; if (di_a !== sim(512)) begin errors++; $display("FAIL mid_restart_di: got %h want %h", di_a, sim(512)); end
  endtask

  initial begin
    test_reset;
    test_threshold;
    test_stream;
    test_underflow;
    test_full;
    test_ena_toggle;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_sink_feeder.md
FFT_SINK_FEEDER -- requirements
Module: fft_sink_feeder

Interface
REQ-001 Parameters: LOG2_N, default 15, log2 of the FFT frame length N; DW, default 16, sample width per component; LOG2_DEPTH, default 4, log2 of the internal FIFO depth D; THRESH, default 8, FIFO level required to start a frame (1..D).
REQ-002 clk  in  1  clock; all logic on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  upstream sample valid.
REQ-005 in_ready  out  1  upstream may push; equals (fifo_count < D).
REQ-006 in_real / in_imag  in  DW each  upstream sample, two's complement.
REQ-007 master_sink_ena  in  1  FFT core ready to accept a sample this cycle.
REQ-008 master_sink_dav  out  1  feeder offers a sample.
REQ-009 master_sink_sop  out  1  offered sample is index 0 of a frame.
REQ-010 data_real_in / data_imag_in  out  DW each  offered sample toward the core.
REQ-011 frame_count  out  16  completed frames, wraps modulo 2^16.
REQ-012 underflow  out  1  sticky: a sample was taken while the FIFO was empty.

Function
REQ-013 Push: on the rising edge with in_valid=1 and in_ready=1, {in_real,in_imag} SHALL be written to the FIFO tail.
REQ-014 Transfer: on the rising edge with master_sink_dav=1 and master_sink_ena=1, one sample SHALL be consumed and sample_idx (LOG2_N bits) SHALL increment.
REQ-015 FIFO is first-word-fall-through: data_real_in/data_imag_in SHALL show the FIFO head combinationally, or zero when the FIFO is empty.
REQ-016 Simultaneous push and transfer SHALL leave fifo_count unchanged; fifo_count SHALL never exceed D and never go below 0.
REQ-017 FSM states: IDLE and STREAM.
REQ-018 IDLE: master_sink_dav=1 iff fifo_count >= THRESH; on a transfer in IDLE the FSM SHALL go to STREAM.
REQ-019 STREAM: master_sink_dav SHALL be 1 unconditionally, so a frame is never stalled by the feeder.
REQ-020 master_sink_sop SHALL equal master_sink_dav AND (sample_idx == 0).
REQ-021 Underflow: a transfer in STREAM with an empty FIFO SHALL send zeros, advance sample_idx, leave fifo_count at 0, and set underflow. The underflow flag is cleared only by reset.
REQ-022 Frame end: a transfer with sample_idx == N-1 SHALL wrap sample_idx to 0 and increment frame_count on the same edge.
REQ-023 At frame end, the FSM SHALL stay in STREAM if the post-edge fifo_count >= THRESH, else go to IDLE.
REQ-024 master_sink_ena=0 SHALL freeze sample_idx, the FIFO head and the FSM state; pushes continue.
REQ-025 Latency: a sample pushed into an empty FIFO SHALL appear on data_*_in the cycle after the push edge.

Reset
REQ-026 While reset=1, on the edge: FSM=IDLE, sample_idx=0, FIFO emptied, frame_count=0, underflow=0.
REQ-027 After reset: master_sink_dav=0, master_sink_sop=0, data_*_in=0, in_ready=1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame and discard FIFO contents; the next frame restarts at index 0 with sop.

Verification
REQ-029 Push 7 samples with master_sink_ena=1 -> dav stays 0. Push the 8th -> next cycle dav=1, sop=1, data = first pushed sample.
REQ-030 With LOG2_N=3, stream 16 samples continuously at ena=1 -> sop on transfers 0 and 8, frame_count=2, underflow=0, output order equals input order.
REQ-031 With LOG2_N=3, starve the input after 5 samples of a frame -> transfers 5..7 carry zeros, underflow=1, frame_count=1, FSM returns to IDLE.
REQ-032 Fill the FIFO to D=16 with ena=0 -> in_ready=0 and further pushes are ignored. Then one cycle with ena=1 and in_valid=1 -> count remains 16 on the following edge only if in_ready was 1; otherwise it becomes 15.
REQ-033 Toggle master_sink_ena 1,0,1,0 mid-frame -> sample_idx advances only on ena=1 edges and data is held during ena=0.
REQ-034 Assert reset at sample_idx=3 for one cycle -> all outputs match REQ-027; the next started frame begins with sop and the first post-reset sample.
